pbch_demapper: RTL and testbench

//  Consumes the PBCH resource elements that FFT_demod emits while PBCH_valid is high, after SSS_detector has found N_id.

---
 rtl/pbch_demapper_if.sv | 29 ++
 rtl/pbch_demapper.sv | 140 ++++++++++++++
 tb/tb_pbch_demapper.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pbch_demapper_if.sv
// Stream bundle for the PBCH demapper: FFT RE input plus the LLR and DMRS output streams.
interface pbch_demapper_if #(
    parameter int IN_DW  = 32,
    parameter int LLR_DW = 8
);
    logic [IN_DW-1:0]    s_axis_in_tdata;
    logic                s_axis_in_tvalid;

    logic [2*LLR_DW-1:0] m_axis_llr_tdata;
    logic                m_axis_llr_tvalid;
    logic                m_axis_llr_tlast;
    logic [8:0]          m_axis_llr_tuser;

    logic [IN_DW-1:0]    m_axis_dmrs_tdata;
    logic                m_axis_dmrs_tvalid;
    logic [7:0]          m_axis_dmrs_tuser;

    modport slave (
        input  s_axis_in_tdata, s_axis_in_tvalid,
        output m_axis_llr_tdata, m_axis_llr_tvalid, m_axis_llr_tlast, m_axis_llr_tuser,
        output m_axis_dmrs_tdata, m_axis_dmrs_tvalid, m_axis_dmrs_tuser
    );

    modport master (
        output s_axis_in_tdata, s_axis_in_tvalid,
        input  m_axis_llr_tdata, m_axis_llr_tvalid, m_axis_llr_tlast, m_axis_llr_tuser,
        input  m_axis_dmrs_tdata, m_axis_dmrs_tvalid, m_axis_dmrs_tuser
    );
endinterface

// File: rtl/pbch_demapper.sv
// Splits the three PBCH symbols of an SSB into QPSK soft bits (data REs) and raw DMRS REs.
module pbch_demapper #(
    parameter int IN_DW     = 32,
    parameter int LLR_DW    = 8,
    parameter int LLR_SHIFT = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [9:0]           N_id_i,
    input  logic                 N_id_valid_i,
    input  logic                 PBCH_start_i,
    pbch_demapper_if.slave       axis,
    output logic                 busy_o,
    output logic                 restart_o
);
    localparam int CW    = IN_DW / 2;
    localparam int POS_I = 2 ** (LLR_DW - 1) - 1;
    localparam logic signed [CW-1:0] POS = CW'(POS_I);
    localparam logic signed [CW-1:0] NEG = CW'(-POS_I);

    typedef enum logic {IDLE, SYM} state_t;

    state_t              state_q;
    logic [9:0]          nid_q;
    logic                nid_ok_q;
    logic [1:0]          v_q;
    logic [1:0]          sym_q;
    logic [7:0]          sc_q;
    logic [8:0]          data_idx_q;
    logic [7:0]          dmrs_idx_q;

    logic [2*LLR_DW-1:0] llr_tdata_q;
    logic                llr_tvalid_q;
    logic                llr_tlast_q;
    logic [8:0]          llr_tuser_q;
    logic [IN_DW-1:0]    dmrs_tdata_q;
    logic                dmrs_tvalid_q;
    logic [7:0]          dmrs_tuser_q;
    logic                restart_q;

    logic                ssb_start, beat, restart, is_sss, is_dmrs, is_data, last_beat;
    logic [1:0]          cur_sym, cur_v;
    logic [7:0]          cur_sc, cur_dmrs_idx;
    logic [8:0]          cur_data_idx;
    logic [2*LLR_DW-1:0] llr_word_d;
    logic                unused_nid_hi;

    assign unused_nid_hi = ^nid_q[9:2];

    // A start beat always re-syncs: the current beat becomes sym 0, sc 0 with a fresh v.
    always_comb begin
        ssb_start    = axis.s_axis_in_tvalid & PBCH_start_i & nid_ok_q;
        beat         = axis.s_axis_in_tvalid & ((state_q == SYM) | ssb_start);
        restart      = ssb_start & (state_q == SYM);
        cur_sym      = ssb_start ? 2'd0 : sym_q;
        cur_sc       = ssb_start ? 8'd0 : sc_q;
        cur_v        = ssb_start ? nid_q[1:0] : v_q;
        cur_data_idx = ssb_start ? 9'd0 : data_idx_q;
        cur_dmrs_idx = ssb_start ? 8'd0 : dmrs_idx_q;
        is_sss       = (cur_sym == 2'd1) && (cur_sc >= 8'd48) && (cur_sc <= 8'd191);
        is_dmrs      = beat & ~is_sss & (cur_sc[1:0] == cur_v);
        is_data      = beat & ~is_sss & (cur_sc[1:0] != cur_v);
        last_beat    = (cur_sym == 2'd2) && (cur_sc == 8'd239);
    end

    // gi = 0 is the real component (low half), gi = 1 the imaginary one.
    for (genvar gi = 0; gi < 2; gi++) begin : g_llr
        logic signed [CW-1:0] shifted;
        assign shifted = $signed(axis.s_axis_in_tdata[gi*CW +: CW]) >>> LLR_SHIFT;
        assign llr_word_d[gi*LLR_DW +: LLR_DW] =
            (shifted > POS) ? POS[LLR_DW-1:0] :
            (shifted < NEG) ? NEG[LLR_DW-1:0] : shifted[LLR_DW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            nid_q         <= '0;
            nid_ok_q      <= 1'b0;
            v_q           <= '0;
            sym_q         <= '0;
            sc_q          <= '0;
            data_idx_q    <= '0;
            dmrs_idx_q    <= '0;
            llr_tdata_q   <= '0;
            llr_tvalid_q  <= 1'b0;
            llr_tlast_q   <= 1'b0;
            llr_tuser_q   <= '0;
            dmrs_tdata_q  <= '0;
            dmrs_tvalid_q <= 1'b0;
            dmrs_tuser_q  <= '0;
            restart_q     <= 1'b0;
        end else begin
            llr_tvalid_q  <= is_data;
            llr_tdata_q   <= is_data ? llr_word_d : '0;
            llr_tuser_q   <= is_data ? cur_data_idx : '0;
            llr_tlast_q   <= is_data && (cur_data_idx == 9'd431);
            dmrs_tvalid_q <= is_dmrs;
            dmrs_tdata_q  <= is_dmrs ? axis.s_axis_in_tdata : '0;
            dmrs_tuser_q  <= is_dmrs ? cur_dmrs_idx : '0;
            restart_q     <= restart;

            // v is captured only at SSB start, so a load taken mid-SSB waits for the next one.
            if (N_id_valid_i) begin
                nid_q    <= N_id_i;
                nid_ok_q <= 1'b1;
            end

            if (beat) begin
                v_q        <= cur_v;
                data_idx_q <= cur_data_idx + 9'(is_data);
                dmrs_idx_q <= cur_dmrs_idx + 8'(is_dmrs);
                if (last_beat) begin
                    state_q <= IDLE;
                    sym_q   <= '0;
                    sc_q    <= '0;
                end else begin
                    state_q <= SYM;
                    if (cur_sc == 8'd239) begin
                        sc_q  <= '0;
                        sym_q <= cur_sym + 2'd1;
                    end else begin
                        sc_q  <= cur_sc + 8'd1;
                        sym_q <= cur_sym;
                    end
                end
            end
        end
    end

    assign busy_o                  = (state_q == SYM);
    assign restart_o               = restart_q;
    assign axis.m_axis_llr_tdata   = llr_tdata_q;
    assign axis.m_axis_llr_tvalid  = llr_tvalid_q;
    assign axis.m_axis_llr_tlast   = llr_tlast_q;
    assign axis.m_axis_llr_tuser   = llr_tuser_q;
    assign axis.m_axis_dmrs_tdata  = dmrs_tdata_q;
    assign axis.m_axis_dmrs_tvalid = dmrs_tvalid_q;
    assign axis.m_axis_dmrs_tuser  = dmrs_tuser_q;
endmodule

// File: tb/tb_pbch_demapper.sv
// Randomized bench for pbch_demapper against a table-driven SSB model.
module tb_pbch_demapper;
    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [9:0] N_id_i = '0;
    logic       N_id_valid_i = 1'b0;
    logic       PBCH_start_i = 1'b0;
    logic       busy_o, restart_o;

    pbch_demapper_if #(.IN_DW(32), .LLR_DW(8)) axis ();

    pbch_demapper #(.IN_DW(32), .LLR_DW(8), .LLR_SHIFT(8)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .N_id_i       (N_id_i),
        .N_id_valid_i (N_id_valid_i),
        .PBCH_start_i (PBCH_start_i),
        .axis         (axis),
        .busy_o       (busy_o),
        .restart_o    (restart_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int llr_cnt = 0, dmrs_cnt = 0, last_cnt = 0;
    bit chk_en = 0;

    // Per-offset SSB map: class (0 = SSS/none, 1 = DMRS, 2 = data) and running index for all 720 positions.
    int tbl_cls [4][720];
    int tbl_idx [4][720];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int llr_of(input logic [15:0] c);
        int x, t;
        x = int'($signed(c));
        t = (x >= 0) ? x / 256 : -((-x + 255) / 256);
        if (t > 127) t = 127;
        if (t < -127) t = -127;
        return t;
    endfunction

    // Model state and expected outputs for the cycle after each posedge
    bit         m_active = 0, m_nid_ok = 0;
    int         m_pos = 0, m_v = 0;
    logic [9:0] m_nid = '0;
    logic       exp_llr_v, exp_llr_last, exp_dmrs_v, exp_busy, exp_restart;
    logic [15:0] exp_llr_data;
    logic [8:0]  exp_llr_user;
    logic [31:0] exp_dmrs_data;
    logic [7:0]  exp_dmrs_user;

    always @(posedge clk) begin
        logic [7:0] lr, li;
        exp_llr_v = 0; exp_llr_last = 0; exp_dmrs_v = 0; exp_restart = 0;
        exp_llr_data = '0; exp_llr_user = '0; exp_dmrs_data = '0; exp_dmrs_user = '0;
        if (reset_i) begin
            m_active = 0; m_nid_ok = 0; m_nid = '0; m_pos = 0;
        end else begin
            if (axis.s_axis_in_tvalid) begin
                if (PBCH_start_i && m_nid_ok) begin
                    exp_restart = m_active;
                    m_active = 1; m_pos = 0; m_v = int'(m_nid) % 4;
                end
                if (m_active) begin
                    if (tbl_cls[m_v][m_pos] == 2) begin
                        lr = 8'(llr_of(axis.s_axis_in_tdata[15:0]));
                        li = 8'(llr_of(axis.s_axis_in_tdata[31:16]));
                        exp_llr_v = 1; exp_llr_data = {li, lr};
                        exp_llr_user = 9'(tbl_idx[m_v][m_pos]);
                        exp_llr_last = (tbl_idx[m_v][m_pos] == 431);
                    end else if (tbl_cls[m_v][m_pos] == 1) begin
                        exp_dmrs_v = 1; exp_dmrs_data = axis.s_axis_in_tdata;
                        exp_dmrs_user = 8'(tbl_idx[m_v][m_pos]);
                    end
                    m_pos++;
                    if (m_pos == 720) m_active = 0;
                end
            end
            if (N_id_valid_i) begin
                m_nid = N_id_i; m_nid_ok = 1;
            end
        end
        exp_busy = m_active;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("llr_valid", 32'(axis.m_axis_llr_tvalid), 32'(exp_llr_v));
            chk("dmrs_valid", 32'(axis.m_axis_dmrs_tvalid), 32'(exp_dmrs_v));
            chk("busy", 32'(busy_o), 32'(exp_busy));
            chk("restart", 32'(restart_o), 32'(exp_restart));
            if (exp_llr_v) begin
                chk("llr_data", 32'(axis.m_axis_llr_tdata), 32'(exp_llr_data));
                chk("llr_user", 32'(axis.m_axis_llr_tuser), 32'(exp_llr_user));
                chk("llr_last", 32'(axis.m_axis_llr_tlast), 32'(exp_llr_last));
            end
            if (exp_dmrs_v) begin
                chk("dmrs_data", axis.m_axis_dmrs_tdata, exp_dmrs_data);
                chk("dmrs_user", 32'(axis.m_axis_dmrs_tuser), 32'(exp_dmrs_user));
            end
            if (axis.m_axis_llr_tvalid) llr_cnt++;
            if (axis.m_axis_dmrs_tvalid) dmrs_cnt++;
            if (axis.m_axis_llr_tvalid && axis.m_axis_llr_tlast) last_cnt++;
        end
    end

    task automatic drive(input logic v, input logic st, input logic [31:0] d);
        axis.s_axis_in_tvalid = v;
        PBCH_start_i = st;
        axis.s_axis_in_tdata = d;
        @(negedge clk);
        axis.s_axis_in_tvalid = 1'b0;
        PBCH_start_i = 1'b0;
    endtask

    task automatic load_nid(input int n);
        N_id_i = 10'(n);
        N_id_valid_i = 1'b1;
        drive(1'b0, 1'b0, '0);
        N_id_valid_i = 1'b0;
    endtask

    // mode 0: ramp re = k<<8, im = -(k<<8); mode 1: random words
    task automatic send(input int n, input bit first_start, input bit gaps, input int mode);
        logic [15:0] re;
        for (int i = 0; i < n; i++) begin
            while (gaps && ($urandom_range(0, 1) == 0)) drive(1'b0, 1'b0, $urandom);
            re = 16'(i << 8);
            drive(1'b1, first_start && (i == 0), (mode == 0) ? {16'(-re), re} : $urandom);
        end
    endtask

    int s_llr, s_dmrs, s_last;
    task automatic snap();
        #1;
        s_llr = llr_cnt; s_dmrs = dmrs_cnt; s_last = last_cnt;
    endtask

    task automatic chk_counts(input string name, input int nl, input int nd, input int nt);
        #1;
        chk({name, "_llr_cnt"}, 32'(llr_cnt - s_llr), 32'(nl));
        chk({name, "_dmrs_cnt"}, 32'(dmrs_cnt - s_dmrs), 32'(nd));
        chk({name, "_tlast_cnt"}, 32'(last_cnt - s_last), 32'(nt));
    endtask

    initial begin
        int nd, nm, nd1;
        axis.s_axis_in_tvalid = 1'b0;
        axis.s_axis_in_tdata  = '0;
        for (int v = 0; v < 4; v++) begin
            nd = 0; nm = 0;
            for (int p = 0; p < 720; p++) begin
                if (p / 240 == 1 && p % 240 >= 48 && p % 240 <= 191) tbl_cls[v][p] = 0;
                else if (p % 240 % 4 == v) begin tbl_cls[v][p] = 1; tbl_idx[v][p] = nm++; end
                else begin tbl_cls[v][p] = 2; tbl_idx[v][p] = nd++; end
            end
            chk("model_data_total", 32'(nd), 32'd432);
            chk("model_dmrs_total", 32'(nm), 32'd144);
        end
        nd1 = 0;
        for (int p = 240; p < 480; p++) if (tbl_cls[2][p] == 2) nd1++;
        chk("model_sym1_data_v2", 32'(nd1), 32'd72);
        chk("model_first_dmrs_v2", 32'(tbl_cls[2][2]), 32'd1);
        chk("model_llr_pos", 32'(llr_of(16'h7FFF)), 32'd127);
        chk("model_llr_neg", 32'(llr_of(16'h8000)), 32'(-127));
        chk("model_llr_one", 32'(llr_of(16'h0100)), 32'd1);
        chk("model_llr_m1", 32'(llr_of(16'hFF00)), 32'(-1));

        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        chk_en = 1;
        drive(1'b0, 1'b0, '0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_llr_valid", 32'(axis.m_axis_llr_tvalid), 32'd0);
        reset_i = 1'b0;

        // Start before any N_id: ignored
        send(20, 1, 0, 1);
        chk("no_nid_busy", 32'(busy_o), 32'd0);

        // Ramp SSB with v = 0
        load_nid(0);
        snap();
        send(720, 1, 0, 0);
        chk_counts("ramp_v0", 432, 144, 1);

        // v = 2, sym1 counted separately
        load_nid(1006);
        send(240, 1, 0, 1);
        snap();
        send(240, 0, 0, 1);
        chk_counts("sym1_v2", 72, 24, 0);
        send(240, 0, 0, 1);

        // Saturation corners at data positions 1 and 2 (v = 0)
        load_nid(0);
        drive(1'b1, 1'b1, $urandom);
        drive(1'b1, 1'b0, {16'h8000, 16'h7FFF});
        chk("sat_a", 32'(axis.m_axis_llr_tdata), 32'h0000_817F);
        drive(1'b1, 1'b0, {16'hFF00, 16'h0100});
        chk("sat_b", 32'(axis.m_axis_llr_tdata), 32'h0000_FF01);
        send(717, 0, 0, 1);

        // v = 1, restart at sym1 sc100
        load_nid(5);
        send(340, 1, 0, 1);
        snap();
        drive(1'b1, 1'b1, $urandom);
        chk("restart_pulse", 32'(restart_o), 32'd1);
        send(719, 0, 0, 1);
        chk_counts("after_restart", 432, 144, 1);

        // Gapped input, reset at sym2 sc10
        load_nid(7);
        send(490, 1, 1, 1);
        reset_i = 1'b1;
        drive(1'b1, 1'b0, $urandom);
        reset_i = 1'b0;
        chk("midreset_busy", 32'(busy_o), 32'd0);
        chk("midreset_llr_valid", 32'(axis.m_axis_llr_tvalid), 32'd0);
        chk("midreset_dmrs_valid", 32'(axis.m_axis_dmrs_tvalid), 32'd0);

        // Fresh SSB with a mid-SSB N_id load, then the SSB that picks it up
        load_nid(7);
        snap();
        send(300, 1, 1, 1);
        load_nid(2);
        send(420, 0, 1, 1);
        chk_counts("gapped_v3", 432, 144, 1);
        snap();
        send(720, 1, 1, 1);
        chk_counts("gapped_v2", 432, 144, 1);
        drive(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
